// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
package pipe_pkg;

  // Occupancy of the stage: nothing held, main slot only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // addi x0,x0,0 -- handy FLUSH_VALUE for instruction-carrying stages.
  localparam logic [31:0] PIPE_NOP_INST = 32'h00000013;

  // Default stall counter width.
  localparam int PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_slot.sv
// One WIDTH-wide payload register: sync reset and clear both load
// FLUSH_VALUE, otherwise loads d when load is high.
module pipe_slot #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Reset and clear take priority over a load in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr)
      r_q <= FLUSH_VALUE;
    else if (load)
      r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Valid/ready elastic pipeline stage with a 2-entry skid so in_ready is a
// pure register output. Optional macro PIPE_STAGE_STALL_CNT_EN adds the
// CNT_W parameter and a saturating stall_cnt output.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}}
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  parameter int               CNT_W       = PIPE_CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_t      r_state;
  logic             r_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_ld;
  logic             w_skid_ld;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // Main refills from upstream, or from skid when draining out of TWO.
  assign w_main_ld = ((r_state == EMPTY) & w_in_fire) |
                     ((r_state == ONE) & w_in_fire & w_out_fire) |
                     ((r_state == TWO) & w_out_fire);
  assign w_main_d  = (r_state == TWO) ? w_skid_q : in_data;
  // Skid only catches the beat that arrives while main is stalled.
  assign w_skid_ld = (r_state == ONE) & w_in_fire & ~w_out_fire;

  // Occupancy FSM; in_ready is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) r_state <= ONE;
          r_in_ready <= 1'b1;
        end
        ONE: begin
          if (w_in_fire && !w_out_fire) begin
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (!w_in_fire && w_out_fire) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.WIDTH(WIDTH), .FLUSH_VALUE(FLUSH_VALUE)) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (w_main_ld),
    .d    (w_main_d),
    .q    (w_main_q)
  );

  pipe_slot #(.WIDTH(WIDTH), .FLUSH_VALUE(FLUSH_VALUE)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (w_skid_ld),
    .d    (in_data),
    .q    (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_main_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles where output is offered but not taken;
  // flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic (FLUSH_VALUE = NOP so flush/reset
// values are distinguishable from zero payloads).
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [1:0]  stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .WIDTH       (32),
    .FLUSH_VALUE (PIPE_NOP_INST)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .CNT_W       (2)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_irdy",   32'(in_ready), 0);
    chk("rst_data",   out_data, PIPE_NOP_INST);

    // Release: in_ready comes up one edge later.
    rst = 1'b0;
    chk("rel_irdy0", 32'(in_ready), 0);
    step();
    chk("rel_irdy1", 32'(in_ready), 1);

    // Back-to-back stream, no backpressure.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11;
    step(); chk("s_11", out_data, 32'h11); chk("s_v11", 32'(out_valid), 1);
    in_data = 32'h22;
    step(); chk("s_22", out_data, 32'h22); chk("s_v22", 32'(out_valid), 1);
    in_data = 32'h33;
    step(); chk("s_33", out_data, 32'h33); chk("s_v33", 32'(out_valid), 1);
    in_valid = 1'b0;
    step(); chk("s_empty", 32'(out_valid), 0);

    // Backpressure: out_ready low for 3 edges.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA0;
    step(); chk("bp_a0", out_data, 32'hA0); chk("bp_irdy1", 32'(in_ready), 1);
    in_data = 32'hA1;
    step(); chk("bp_hold1", out_data, 32'hA0); chk("bp_irdy0", 32'(in_ready), 0);
    in_data = 32'hA2;
    step(); chk("bp_hold2", out_data, 32'hA0); chk("bp_irdy0b", 32'(in_ready), 0);
    out_ready = 1'b1;
    step(); chk("bp_a1", out_data, 32'hA1); chk("bp_irdy1b", 32'(in_ready), 1);
    step(); chk("bp_a2", out_data, 32'hA2);
    in_data = 32'hA3;
    step(); chk("bp_a3", out_data, 32'hA3);
    in_valid = 1'b0;
    step(); chk("bp_empty", 32'(out_valid), 0);

    // Flush while TWO with a pending input that must be dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hB0;
    step(); in_data = 32'hB1;
    step(); chk("fl_two_irdy", 32'(in_ready), 0); chk("fl_two_data", out_data, 32'hB0);
    in_data = 32'hB2; flush = 1'b1;
    step();
    chk("fl_ovalid", 32'(out_valid), 0);
    chk("fl_data",   out_data, PIPE_NOP_INST);
    chk("fl_irdy",   32'(in_ready), 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); chk("fl_no_b2", 32'(out_valid), 0); chk("fl_no_b2d", out_data, PIPE_NOP_INST);

    // Flush coinciding with out_fire in ONE.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC0;
    step(); in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    chk("ff_offer_v", 32'(out_valid), 1); chk("ff_offer_d", out_data, 32'hC0);
    step(); chk("ff_ovalid", 32'(out_valid), 0); chk("ff_irdy", 32'(in_ready), 1);
    flush = 1'b0;
    step(); chk("ff_noreplay", 32'(out_valid), 0);

    // Reset while TWO.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD0;
    step(); in_data = 32'hD1;
    step(); chk("rt_two", 32'(in_ready), 0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("rt_ovalid", 32'(out_valid), 0);
    chk("rt_irdy",   32'(in_ready), 0);
    chk("rt_data",   out_data, PIPE_NOP_INST);
    rst = 1'b0;
    step(); chk("rt_irdy1", 32'(in_ready), 1); chk("rt_ovalid1", 32'(out_valid), 0);
    // Drain check: next accept must be the only entry (skid did not survive).
    in_valid = 1'b1; in_data = 32'hE0; out_ready = 1'b1;
    step(); chk("rt_e0", out_data, 32'hE0);
    in_valid = 1'b0;
    step(); chk("rt_e0_only", 32'(out_valid), 0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    rst = 1'b1; step(); rst = 1'b0; step();
    chk("sc_zero", 32'(stall_cnt), 0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hF0;
    step(); in_valid = 1'b0;
    chk("sc_pre", 32'(stall_cnt), 0);
    step(); chk("sc_1", 32'(stall_cnt), 1);
    step(); chk("sc_2", 32'(stall_cnt), 2);
    step(); chk("sc_3", 32'(stall_cnt), 3);
    step(); chk("sc_3b", 32'(stall_cnt), 3);
    step(); chk("sc_3c", 32'(stall_cnt), 3);
    step(); chk("sc_3d", 32'(stall_cnt), 3);
    flush = 1'b1;
    step(); flush = 1'b0; chk("sc_flush", 32'(stall_cnt), 3);
    rst = 1'b1;
    step(); rst = 1'b0; chk("sc_rst", 32'(stall_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
